dmem_arbiter: RTL and testbench

- Shares the single data_mem port between two requesters:
  - port 0: CPU load/store unit.
  - port 1: debug/DMA loader.
- Drives data_mem's addr/write_data/memwrite/memread/sign_mask and tracks its clk_stall handshake.
- Issues each access as a one-cycle command pulse, holds it stable until data_mem completes, then returns a one-cycle acknowledge with read data.
- Sits between the pipeline/loader and data_mem.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 86 ++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and data_mem signals shared by the two-port data memory arbiter.
// master = requester/memory side, slave = arbiter side.
interface dmem_arbiter_if;
   logic        req0, req1, re0, re1, we0, we1, ack0, ack1;
   logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
   logic [3:0]  mask0, mask1, mem_sign_mask;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_memwrite, mem_memread, mem_clk_stall, busy, err;

   modport master (
      output req0, req1, re0, re1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
             mem_read_data, mem_clk_stall,
      input  ack0, ack1, rdata0, rdata1, mem_addr, mem_write_data, mem_memwrite, mem_memread,
             mem_sign_mask, busy, err
   );

   modport slave (
      input  req0, req1, re0, re1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
             mem_read_data, mem_clk_stall,
      output ack0, ack1, rdata0, rdata1, mem_addr, mem_write_data, mem_memwrite, mem_memread,
             mem_sign_mask, busy, err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_mem port between the CPU LSU (port 0) and the debug/DMA loader (port 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has strict priority.
module dmem_arbiter #(
   parameter int STALL_TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   localparam int CW = $clog2(STALL_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_n;
   logic id, rd, seen_stall, go, gnt, sel_re, sel_we, cur, fin, tmo;
   logic [CW-1:0] cnt;
`ifdef DMEM_ARB_RR_EN
   logic ptr;
   assign gnt = (bus.req0 && bus.req1) ? ptr : bus.req1;
`else
   assign gnt = !bus.req0;
`endif
   // data_mem has no reset, so never issue while it still reports a stall
   assign go = state == IDLE && !bus.mem_clk_stall && (bus.req0 || bus.req1);
   assign sel_re = gnt ? bus.re1 : bus.re0;
   assign sel_we = gnt ? bus.we1 : bus.we0;
   assign cur = state == IDLE ? gnt : id;
   assign fin = seen_stall && !bus.mem_clk_stall;
   assign tmo = cnt == CW'(STALL_TIMEOUT);
   assign bus.busy = state != IDLE;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (go) state_n = (sel_re || sel_we) ? ISSUE : DONE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (fin || tmo) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         {bus.ack0, bus.ack1, bus.mem_memread, bus.mem_memwrite, bus.err} <= '0;
         {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_write_data} <= '0;
         bus.mem_sign_mask <= '0;
         {id, rd, seen_stall} <= '0;
         cnt <= '0;
`ifdef DMEM_ARB_RR_EN
         ptr <= 1'b0;
`endif
      end else begin
         bus.ack0 <= state_n == DONE && !cur;
         bus.ack1 <= state_n == DONE && cur;
         if (go) begin
            id <= gnt;
            rd <= sel_re;
            bus.mem_addr <= gnt ? bus.addr1 : bus.addr0;
            bus.mem_write_data <= gnt ? bus.wdata1 : bus.wdata0;
            bus.mem_sign_mask <= gnt ? bus.mask1 : bus.mask0;
            bus.mem_memread <= sel_re;
            bus.mem_memwrite <= sel_we && !sel_re;
         end
         if (state == ISSUE) {bus.mem_memread, bus.mem_memwrite} <= '0;
         if (state == WAIT) begin
            seen_stall <= seen_stall || bus.mem_clk_stall;
            cnt <= cnt + 1'b1;
            // a completed write leaves rdata alone; a timeout forces it to zero
            if (fin ? rd : tmo) begin
               if (id) bus.rdata1 <= fin ? bus.mem_read_data : '0;
               else bus.rdata0 <= fin ? bus.mem_read_data : '0;
            end
            if (!fin && tmo) bus.err <= 1'b1;
         end
         if (state == DONE) begin
            seen_stall <= 1'b0;
            cnt <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr <= !id;
`endif
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a scoreboard of expected acks checked by a negedge monitor.
module tb_dmem_arbiter;
   localparam int ST = 15;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   dmem_arbiter_if bus();
   dmem_arbiter #(.STALL_TIMEOUT(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {bit port; logic [31:0] rdata; int cyc; bit err;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0, cyc = 0, rd_pulses = 0, wr_pulses = 0;
   int last_rd_cyc = -1, last_wr_cyc = -1, stall_cnt = 0, stall_len = 2;
   logic [31:0] last_addr = 0, last_wdata = 0;
   logic [3:0] last_mask = 0;
   bit hang = 0, hang_on = 0, prev_ack = 0;
   logic [31:0] mem [64] = '{4: 32'hDEADBEEF, 8: 32'h11111111, 12: 32'h22222222, default: 32'h0};

   // data_mem model: samples a command pulse, then stalls stall_len cycles (or forever when hang)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!hang) hang_on <= 1'b0;
      if (bus.mem_memread || bus.mem_memwrite) begin
         if (bus.mem_memwrite) mem[bus.mem_addr[7:2]] <= bus.mem_write_data;
         bus.mem_read_data <= mem[bus.mem_addr[7:2]];
         stall_cnt <= stall_len;
         if (hang) hang_on <= 1'b1;
      end else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
   end
   assign bus.mem_clk_stall = stall_cnt != 0 || hang_on;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_memread) begin
         rd_pulses++;
         last_rd_cyc = cyc;
         last_addr = bus.mem_addr;
         last_mask = bus.mem_sign_mask;
      end
      if (bus.mem_memwrite) begin
         wr_pulses++;
         last_wr_cyc = cyc;
         last_wdata = bus.mem_write_data;
      end
      if (bus.ack0 || bus.ack1) begin
         chk("ack_width", prev_ack, 0);
         chk("strobe_in_ack", bus.mem_memread || bus.mem_memwrite, 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ack0=%b ack1=%b at cycle %0d, none expected", bus.ack0, bus.ack1, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_port", bus.ack1, e.port);
            chk("ack_single", bus.ack0 && bus.ack1, 0);
            chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.rdata);
            chk("ack_cycle", cyc, e.cyc);
            chk("err_at_ack", bus.err, e.err);
         end
      end
      prev_ack = bus.ack0 || bus.ack1;
   end

   task automatic drive(input bit p, input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
      if (p) begin
         bus.req1 = 1; bus.re1 = re; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.mask1 = m;
      end else begin
         bus.req0 = 1; bus.re0 = re; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.mask0 = m;
      end
   endtask

   task automatic wait_ack(input bit p);
      bit got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = p ? bus.ack1 : bus.ack0;
      end
      chk("ack_seen", got, 1);
      if (!got) sb.delete();
      @(posedge clk); #1;
      if (p) bus.req1 = 0; else bus.req0 = 0;
   endtask

   task automatic access(input bit p, input bit re, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input logic [31:0] exp_rd,
                         input int lat, input bit exp_err, output int c0);
      @(posedge clk); #1;
      drive(p, re, we, a, wd, m);
      c0 = cyc;
      sb.push_back('{p, exp_rd, c0 + lat, exp_err});
      wait_ack(p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, rp, wp, n;
      bit p;
      {bus.req0, bus.req1, bus.re0, bus.re1, bus.we0, bus.we1} = '0;
      {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
      {bus.mask0, bus.mask1} = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_acks", {bus.ack0, bus.ack1}, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_strobes", {bus.mem_memread, bus.mem_memwrite}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rdata0", bus.rdata0, 0);

      rp = rd_pulses;
      access(0, 1, 0, 32'h10, 0, 4'b0111, 32'hDEADBEEF, 5, 0, c0);
      chk("rd_pulses", rd_pulses - rp, 1);
      chk("rd_cycle", last_rd_cyc, c0 + 1);
      chk("rd_mask", last_mask, 4'b0111);
      chk("rd_addr", last_addr, 32'h10);

      rp = rd_pulses; wp = wr_pulses;
      access(1, 0, 1, 32'h24, 32'h12345678, 4'b0111, 32'h0, 5, 0, c0);
      chk("wr_pulses", wr_pulses - wp, 1);
      chk("wr_cycle", last_wr_cyc, c0 + 1);
      chk("wr_data", last_wdata, 32'h12345678);
      chk("wr_no_read", rd_pulses - rp, 0);
      access(0, 1, 0, 32'h24, 0, 4'b0111, 32'h12345678, 5, 0, c0);

      rp = rd_pulses; wp = wr_pulses;
      access(0, 1, 1, 32'h10, 32'hAAAA5555, 4'b0111, 32'hDEADBEEF, 5, 0, c0);
      chk("rw_read", rd_pulses - rp, 1);
      chk("rw_no_write", wr_pulses - wp, 0);
      chk("rw_mem_kept", mem[4], 32'hDEADBEEF);

      rp = rd_pulses; wp = wr_pulses;
      access(1, 0, 0, 32'h30, 0, 4'b0000, 32'h0, 1, 0, c0);
      chk("noop_no_cmd", (rd_pulses - rp) + (wr_pulses - wp), 0);

      @(posedge clk); #1;
      drive(0, 1, 0, 32'h20, 0, 4'b1111);
      drive(1, 1, 0, 32'h30, 0, 4'b1111);
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         p = RR ? k[0] : 1'b0;
         sb.push_back('{p, p ? 32'h22222222 : 32'h11111111, c0 + 5 + 6 * k, 0});
      end
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) n++;
      end
      chk("contention_acks", n, 4);
      @(posedge clk); #1;
      bus.req0 = 0; bus.req1 = 0;

      @(posedge clk); #1;
      stall_len = 6;
      rp = rd_pulses;
      drive(0, 1, 0, 32'h20, 0, 4'b0111);
      c0 = cyc;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      stall_len = 2;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("midrst_ack0", bus.ack0, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_strobe", bus.mem_memread, 0);
      chk("midrst_mem_addr", bus.mem_addr, 0);
      chk("midrst_rdata0", bus.rdata0, 0);
      sb.push_back('{1'b0, 32'h11111111, c0 + 13, 1'b0});
      wait_ack(0);
      chk("midrst_reissue_cycle", last_rd_cyc, c0 + 9);
      chk("midrst_rd_pulses", rd_pulses - rp, 2);

      hang = 1;
      access(0, 1, 0, 32'h20, 0, 4'b0111, 32'h0, 2 + ST + 1, 1, c0);
      repeat (3) begin
         @(negedge clk);
         chk("err_sticky", bus.err, 1);
      end
      hang = 0;
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("err_cleared", bus.err, 0);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
